// File: rtl/oled_console_if.sv
// Byte-stream handshake into oled_console: producer drives ch_valid/ch_data, console returns ch_ready.
interface oled_console_if;
  logic       ch_valid;
  logic [7:0] ch_data;
  logic       ch_ready;

  modport master (output ch_valid, output ch_data, input ch_ready);
  modport slave  (input ch_valid, input ch_data, output ch_ready);
endinterface

// File: rtl/oled_console.sv
// Console front end for the 4x16 OLED text buffer: cursor, control chars, clear and scroll.
// Optional scrolling (shadow copy + SCROLL state) is built only when OLED_CONSOLE_SCROLL_EN is defined.
module oled_console #(
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic          clock_mem,
  input  logic          rst_n,
  oled_console_if.slave ch,
  input  logic          clear,
  output logic [5:0]    addr,
  output logic [7:0]    store_data,
  output logic          store_we,
  output logic          busy,
  output logic [5:0]    cursor
);

`ifdef OLED_CONSOLE_SCROLL_EN
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_SCROLL} state_t;
`else
  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE} state_t;
`endif

  state_t     state;
  logic [5:0] idx;
  logic [1:0] row;
  logic       is_print;
  logic       run_off;

  assign ch.ch_ready = (state == ST_IDLE) && !clear;
  assign busy        = (state != ST_IDLE);
  assign row         = cursor[5:4];
  assign is_print    = (ch.ch_data >= 8'h20) && (ch.ch_data <= 8'h7E);
  // Cursor leaving the bottom of the screen: printable at the last cell, or LF on the last row.
  assign run_off     = (is_print && (cursor == 6'd63)) || ((ch.ch_data == 8'h0A) && (row == 2'd3));

`ifdef OLED_CONSOLE_SCROLL_EN
  logic [7:0] shadow [64];
  logic [7:0] scroll_dat;

  // Mirrors the device buffer; lands at the end of the cycle the strobe is presented.
  always_ff @(posedge clock_mem) begin
    if (store_we) shadow[addr] <= store_data;
  end

  assign scroll_dat = (idx < 6'd48) ? shadow[idx + 6'd16] : FILL_CHAR;
`endif

  always_ff @(posedge clock_mem or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      idx        <= 6'd0;
      addr       <= 6'd0;
      store_data <= 8'h00;
      store_we   <= 1'b0;
      cursor     <= 6'd0;
    end else begin
      store_we <= 1'b0;
      case (state)
        ST_CLEAR: begin
          store_we   <= 1'b1;
          addr       <= idx;
          store_data <= FILL_CHAR;
          idx        <= idx + 6'd1;
          if (idx == 6'd63) begin
            state  <= ST_IDLE;
            cursor <= 6'd0;
          end
        end
        ST_IDLE: begin
          if (clear) begin
            state <= ST_CLEAR;
            idx   <= 6'd0;
          end else if (ch.ch_valid) begin
            if (is_print) begin
              store_we   <= 1'b1;
              addr       <= cursor;
              store_data <= ch.ch_data;
            end
            if (run_off) begin
`ifdef OLED_CONSOLE_SCROLL_EN
              state <= ST_SCROLL;
              idx   <= 6'd0;
`else
              cursor <= 6'd0;
`endif
            end else if (is_print) begin
              cursor <= cursor + 6'd1;
            end else begin
              case (ch.ch_data)
                8'h0A: cursor <= {row + 2'd1, 4'd0};
                8'h0D: cursor <= {row, 4'd0};
                8'h08: begin
                  if (cursor != 6'd0) begin
                    cursor     <= cursor - 6'd1;
                    store_we   <= 1'b1;
                    addr       <= cursor - 6'd1;
                    store_data <= FILL_CHAR;
                  end
                end
                default: ;
              endcase
            end
          end
        end
`ifdef OLED_CONSOLE_SCROLL_EN
        ST_SCROLL: begin
          store_we   <= 1'b1;
          addr       <= idx;
          store_data <= scroll_dat;
          idx        <= idx + 6'd1;
          if (idx == 6'd63) begin
            state  <= ST_IDLE;
            cursor <= 6'd48;
          end
        end
`endif
        default: begin
          state <= ST_CLEAR;
          idx   <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/oled_console.md
# oled_console

Character-stream front end for the memory-mapped OLED text buffer. It accepts ASCII bytes over a valid/ready handshake and interprets control characters with a cursor. It emits single-byte writes on the OLED device's `addr`/`store_data`/`store_we` port, scrolling the 4×16 text buffer when the cursor runs off the bottom. It sits directly upstream of the OLED device, between a byte producer (CPU MMIO register or UART RX) and the display buffer.

## Interface
- `FILL_CHAR`, default 8'h20: byte written by clear, backspace and scroll-in.
- `clock_mem`  in  1: clock; same clock that drives the OLED device buffer.
- `rst_n`  in  1: one clock; reset is asynchronous and active-low.
- `ch_valid`  in  1: producer offers `ch_data`.
- `ch_data`  in  8: ASCII byte.
- `ch_ready`  out  1: combinational; equals `state==IDLE && !clear`.
- `clear`  in  1: request a full-screen clear; sampled only in IDLE.
- `addr`  out  6: character index, `{row[1:0], col[3:0]}`; registered.
- `store_data`  out  8: byte to write; registered.
- `store_we`  out  1: write strobe, one cycle per character; registered.
- `busy`  out  1: high in CLEAR or SCROLL.
- `cursor`  out  6: current cursor index; registered.

## Operation
- The block keeps an internal 64×8 shadow copy of everything it has written. The shadow is the source for scroll copies, because the OLED device has no read path usable here.
- Every `store_we` pulse writes the shadow entry at the same index in the same cycle.
- States:
  - CLEAR: index counter 0..63; writes `FILL_CHAR` to `addr`=index; after index 63, goes to IDLE with `cursor`=0.
  - IDLE: accepts characters.
  - SCROLL: index 0..47 writes `shadow[index+16]` to `addr`=index; index 48..63 writes `FILL_CHAR`; after index 63, goes to IDLE with `cursor`=48.
- Accepted byte, handled in IDLE:
  - 0x20–0x7E: write the byte at `cursor`. If `cursor`==63, go to SCROLL; otherwise `cursor`+1.
  - 0x0A (LF): no write. If row==3, go to SCROLL; otherwise `cursor`={row+1, 0}.
  - 0x0D (CR): no write; `cursor`={row, 0}.
  - 0x08 (BS): if `cursor`==0, no-op. Otherwise `cursor`-1 and write `FILL_CHAR` at `cursor`-1. BS crosses rows (16 → 15).
  - Any other byte: consumed, no effect.
- `clear` high in IDLE: enter CLEAR; index=0. A simultaneous `ch_valid` is not accepted, because `ch_ready` is low.
- `clear` outside IDLE is ignored; the requester must hold it until `busy` is low.
- Reset mid-operation aborts any CLEAR or SCROLL and restarts CLEAR from index 0.

## Timing
- Reset values: `store_we`=0, `addr`=0, `store_data`=0, `cursor`=0, `busy`=1, `ch_ready`=0, state=CLEAR, index=0.
- After `rst_n` rises, 64 consecutive cycles carry `store_we`=1 with `addr`=0..63 and `store_data`=`FILL_CHAR`. IDLE follows, with `ch_ready`=1.
- Handshake: transfer occurs at the posedge where `ch_valid && ch_ready`. The write appears on the outputs for the following cycle.
- Throughput: one printable byte per cycle with no bubbles, until a scroll is triggered.
- Scroll: the cycle after the triggering write (or LF), state is SCROLL. It runs 64 write cycles, then IDLE. Total `ch_ready` low time is 64 cycles.
- Outputs change on posedge only. The OLED device samples at negedge, so `addr`/`store_data`/`store_we` are stable half a cycle before use.
- `cursor` updates in the same posedge as the write it causes.

## Configuration
- `OLED_CONSOLE_SCROLL_EN`, defined:
  - Behaviour as above.
- `OLED_CONSOLE_SCROLL_EN`, undefined:
  - SCROLL state and shadow buffer are not built.
  - Any condition that would scroll instead sets `cursor`=0 (printable at 63, LF on row 3). No extra writes are issued.
  - `busy` is high only in CLEAR.
  - Existing text is overwritten in place.

## Test plan
- Reset release -> 64 writes of 0x20 to `addr` 0..63 on consecutive cycles; then `ch_ready`=1, `cursor`=0.
- Send "HI" back-to-back -> writes (0,0x48) then (1,0x49) on consecutive cycles; `cursor`=2.
- Send 'A', CR, BS; then BS at `cursor`=0 -> 'A' written at 0, `cursor` 1→0. BS at 0 produces no write and leaves `cursor`=0.
- Fill 64 printable bytes 0x30+(i%10) -> write at 63, then 64 scroll writes. Scroll data: `addr` i gets byte 0x30+((i+16)%10) for i<48, 0x20 for i≥48. Final `cursor`=48. Without the macro: `cursor`=0 and no scroll writes.
- LF at `cursor`=50 -> no write, SCROLL entered, `cursor`=48 afterwards.
- `clear`=1 and `ch_valid`=1 ('Z') in the same IDLE cycle -> 'Z' not accepted; 64 clear writes follow; 'Z' is accepted afterwards at `cursor`=0.
